// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: instruction fetch stage with an in-order prefetch FIFO.
// Issues word fetches under a credit limit and keeps fetched words with their PCs.
// A redirect flushes the FIFO, and responses that were still in flight are discarded.
// Optional macro PREFETCH_STATS_EN adds the stall_cnt_o and redirect_cnt_o counters.
module instr_prefetch_buffer #(
    parameter int                 RegBits = 32,
    parameter int                 Depth   = 4,
    parameter logic [RegBits-1:0] ResetPc = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               mem_req_o,
    output logic [RegBits-1:0] mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [RegBits-1:0] mem_rdata_i,
    output logic               instr_valid_o,
    output logic [RegBits-1:0] instr_o,
    output logic [RegBits-1:0] instr_pc_o,
    input  logic               instr_ready_i,
    input  logic               redirect_i,
`ifdef PREFETCH_STATS_EN
    input  logic [RegBits-1:0] redirect_pc_i,
    output logic [31:0]        stall_cnt_o,
    output logic [15:0]        redirect_cnt_o
`else
    input  logic [RegBits-1:0] redirect_pc_i
`endif
);

    localparam int PtrBits = $clog2(Depth);
    localparam int CntBits = PtrBits + 2;

    logic [RegBits-1:0] r_dataMem [Depth];
    logic [RegBits-1:0] r_pcMem   [Depth];
    logic [PtrBits-1:0] r_rdPtr;
    logic [PtrBits-1:0] r_wrPtr;
    logic [CntBits-1:0] r_count;
    logic [CntBits-1:0] r_outstanding;
    logic [CntBits-1:0] r_discard;
    logic [RegBits-1:0] r_fetchPc;
    logic [RegBits-1:0] r_pcTag;

    logic               w_grant;
    logic               w_respKnown;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic [CntBits-1:0] w_inFlight;
    logic [RegBits-1:0] w_redirPc;

    // Credit and handshake decode: occupancy plus everything still in flight is capped at Depth
    always_comb begin
        w_inFlight    = r_count + r_outstanding + r_discard;
        mem_req_o     = rst_i && !redirect_i && (w_inFlight < CntBits'(Depth));
        mem_addr_o    = r_fetchPc;
        w_grant       = mem_req_o && mem_gnt_i;
        w_respKnown   = mem_rvalid_i && ((r_discard != '0) || (r_outstanding != '0));
        w_drop        = mem_rvalid_i && (r_discard != '0);
        w_push        = mem_rvalid_i && (r_discard == '0) && (r_outstanding != '0);
        instr_valid_o = (r_count != '0);
        w_pop         = instr_valid_o && instr_ready_i && !redirect_i;
        w_redirPc     = {redirect_pc_i[RegBits-1:2], 2'b00};
        instr_o       = r_dataMem[r_rdPtr];
        instr_pc_o    = r_pcMem[r_rdPtr];
    end

    // Fetch PC, request/discard bookkeeping and FIFO storage; a redirect wins over everything else
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetchPc     <= ResetPc;
            r_pcTag       <= ResetPc;
            r_rdPtr       <= '0;
            r_wrPtr       <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_dataMem[i] <= '0;
                r_pcMem[i]   <= '0;
            end
        end else if (redirect_i) begin
            r_fetchPc     <= w_redirPc;
            r_pcTag       <= w_redirPc;
            r_rdPtr       <= '0;
            r_wrPtr       <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= r_discard + r_outstanding - {{(CntBits-1){1'b0}}, w_respKnown};
        end else begin
            if (w_grant) begin
                r_fetchPc <= r_fetchPc + RegBits'(4);
            end
            r_outstanding <= r_outstanding + {{(CntBits-1){1'b0}}, w_grant}
                                           - {{(CntBits-1){1'b0}}, w_push};
            r_discard     <= r_discard - {{(CntBits-1){1'b0}}, w_drop};
            if (w_push) begin
                r_dataMem[r_wrPtr] <= mem_rdata_i;
                r_pcMem[r_wrPtr]   <= r_pcTag;
                r_wrPtr            <= r_wrPtr + PtrBits'(1);
                r_pcTag            <= r_pcTag + RegBits'(4);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PtrBits'(1);
            end
            r_count <= r_count + {{(CntBits-1){1'b0}}, w_push}
                               - {{(CntBits-1){1'b0}}, w_pop};
        end
    end

`ifdef PREFETCH_STATS_EN
    // Saturating counters for consumer stalls on an empty FIFO and for redirects taken
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o    <= '0;
            redirect_cnt_o <= '0;
        end else begin
            if (instr_ready_i && !instr_valid_o && !redirect_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (redirect_i && (redirect_cnt_o != 16'hFFFF)) begin
                redirect_cnt_o <= redirect_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: randomized bench for instr_prefetch_buffer.
// A memory model returns words in order with random latency. The reference is kept as
// a queue of fetched PCs plus a list of in-flight requests tagged with a redirect epoch.
module tb_instr_prefetch_buffer;

    localparam int Depth = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef PREFETCH_STATS_EN
    logic [31:0] stall_cnt_o;
    logic [15:0] redirect_cnt_o;
`endif

    instr_prefetch_buffer #(.RegBits(32), .Depth(Depth), .ResetPc(32'h0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
`ifdef PREFETCH_STATS_EN
        .redirect_pc_i (redirect_pc_i),
        .stall_cnt_o   (stall_cnt_o),
        .redirect_cnt_o(redirect_cnt_o)
`else
        .redirect_pc_i (redirect_pc_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pending[$];
    logic [31:0] fifoPc[$];
    int          epoch;
    int          cycle;
    logic [31:0] modelFetchPc;
    logic [31:0] modelStall;
    logic [15:0] modelRedir;
    int          total;
    int          bad;
    bit          forceRedir;
    logic [31:0] forcePc;

    // Instruction word stored at a given address in the memory model
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h1234_5678;
    endfunction

    // Single comparison point: counts every check and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Clear the reference model to its post-reset state
    task automatic clearModel();
        pending.delete();
        fifoPc.delete();
        epoch        = 0;
        modelFetchPc = 32'h0;
        modelStall   = 32'h0;
        modelRedir   = 16'h0;
    endtask

    // Reset assertion with checks of the cleared outputs while reset is held
    task automatic doReset();
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        rst_i         = 1'b0;
        clearModel();
        #1;
        checkOutput("rst_req", {31'h0, mem_req_o}, 32'h0);
        checkOutput("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        checkOutput("rst_instr", instr_o, 32'h0);
        checkOutput("rst_pc", instr_pc_o, 32'h0);
`ifdef PREFETCH_STATS_EN
        checkOutput("rst_stall", stall_cnt_o, 32'h0);
        checkOutput("rst_redir", {16'h0, redirect_cnt_o}, 32'h0);
`endif
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance the model at posedge
    task automatic applyStimulus(input int readyPct, input int gntPct, input int redirPct, input int spurPct);
        bit          expReq;
        bit          respond;
        bit          pop;
        bit          grant;
        logic [31:0] newPc;
        req_t        r;

        mem_gnt_i     = ($urandom_range(99) < gntPct);
        instr_ready_i = ($urandom_range(99) < readyPct);
        if (forceRedir) begin
            redirect_i    = 1'b1;
            redirect_pc_i = forcePc;
            forceRedir    = 1'b0;
        end else begin
            redirect_i    = ($urandom_range(99) < redirPct);
            redirect_pc_i = $urandom();
        end
        respond = 1'b0;
        if (pending.size() > 0 && pending[0].due <= cycle) begin
            respond      = 1'b1;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memWord(pending[0].addr);
        end else if (pending.size() == 0 && $urandom_range(99) < spurPct) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom();
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom();
        end

        @(negedge clk_i);
        expReq = !redirect_i && ((fifoPc.size() + pending.size()) < Depth);
        checkOutput("req", {31'h0, mem_req_o}, {31'h0, expReq});
        if (expReq) checkOutput("addr", mem_addr_o, modelFetchPc);
        checkOutput("valid", {31'h0, instr_valid_o}, {31'h0, fifoPc.size() != 0});
        if (fifoPc.size() != 0) begin
            checkOutput("head_pc", instr_pc_o, fifoPc[0]);
            checkOutput("head_instr", instr_o, memWord(fifoPc[0]));
        end
`ifdef PREFETCH_STATS_EN
        checkOutput("stall_cnt", stall_cnt_o, modelStall);
        checkOutput("redir_cnt", {16'h0, redirect_cnt_o}, {16'h0, modelRedir});
`endif

        @(posedge clk_i);
        grant = expReq && mem_gnt_i;
        pop   = (fifoPc.size() != 0) && instr_ready_i && !redirect_i;
        if (instr_ready_i && fifoPc.size() == 0 && !redirect_i && modelStall != 32'hFFFF_FFFF)
            modelStall = modelStall + 32'd1;
        if (redirect_i) begin
            if (respond) void'(pending.pop_front());
            epoch++;
            fifoPc.delete();
            newPc        = redirect_pc_i;
            modelFetchPc = {newPc[31:2], 2'b00};
            if (modelRedir != 16'hFFFF) modelRedir = modelRedir + 16'd1;
        end else begin
            if (pop) void'(fifoPc.pop_front());
            if (respond) begin
                r = pending.pop_front();
                if (r.epoch == epoch) fifoPc.push_back(r.addr);
            end
            if (grant) begin
                r.addr  = modelFetchPc;
                r.epoch = epoch;
                r.due   = cycle + 1 + int'($urandom_range(2));
                pending.push_back(r);
                modelFetchPc = modelFetchPc + 32'd4;
            end
        end
        cycle++;
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cycle      = 0;
        forceRedir = 1'b0;
        forcePc    = 32'h0;
        doReset();

        // streaming from reset with a memory that always grants
        repeat (20) applyStimulus(100, 100, 0, 0);
        // consumer stalled: FIFO fills and requests stop, then single pops
        repeat (12) applyStimulus(0, 100, 0, 0);
        repeat (3) begin
            applyStimulus(100, 100, 0, 0);
            repeat (4) applyStimulus(0, 100, 0, 0);
        end
        // redirect with requests in flight, misaligned target
        forceRedir = 1'b1;
        forcePc    = 32'h203;
        repeat (15) applyStimulus(100, 100, 0, 0);
        forceRedir = 1'b1;
        forcePc    = 32'h100;
        repeat (15) applyStimulus(70, 100, 0, 0);
        // address wrap at the top of the space
        forceRedir = 1'b1;
        forcePc    = 32'hFFFF_FFF4;
        repeat (15) applyStimulus(100, 100, 0, 0);
        // memory never grants while the consumer waits, plus stray responses
        repeat (12) applyStimulus(100, 0, 0, 50);
        // back-to-back redirects
        repeat (6) applyStimulus(50, 100, 0, 0);
        repeat (3) applyStimulus(50, 100, 100, 0);
        repeat (10) applyStimulus(50, 100, 0, 0);
        // random mix
        repeat (1500) applyStimulus($urandom_range(100), $urandom_range(100), 5, 10);
        // reset in the middle of traffic
        repeat (5) applyStimulus(50, 100, 0, 0);
        doReset();
        repeat (1500) applyStimulus($urandom_range(100), $urandom_range(100), 8, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Instruction-fetch stage that sits upstream of the single-cycle core datapath.
- Issues word requests to a handshaked instruction memory port, keeps up to Depth fetched words with their PCs in an in-order FIFO, and presents them to the decode side.
- Handles control-flow redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
- RegBits, 32, data/address width.
- Depth, 4, FIFO entries; also the cap on FIFO occupancy plus outstanding requests (power of 2, ≥2).
- ResetPc, 32'h0, first fetch address after reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_req_o  out  1  fetch request valid.
- mem_addr_o  out  RegBits  word-aligned fetch address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  response valid; responses return in request order.
- mem_rdata_i  in  RegBits  response instruction word.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  RegBits  FIFO head instruction.
- instr_pc_o  out  RegBits  PC of FIFO head.
- instr_ready_i  in  1  consumer takes head when asserted with instr_valid_o.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  RegBits  new fetch PC; bits [1:0] are forced to 0.

Behaviour:
- Reset (rst_i low, async):
  - fetch_pc = ResetPc; FIFO empty; outstanding = 0; discard = 0.
  - mem_req_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0.
- Credit rule: mem_req_o = !redirect_i && (fifo_count + outstanding + discard < Depth).
  - The FIFO can never overflow, so no response is ever dropped for lack of space.
- mem_addr_o = fetch_pc. It holds stable while mem_req_o is high and mem_gnt_i is low, except in the cycle after a redirect.
- Grant (mem_req_o && mem_gnt_i): fetch_pc += 4, wrapping modulo 2^RegBits; outstanding += 1.
- Response (mem_rvalid_i):
  - If discard > 0: discard −= 1 and the data is dropped.
  - Otherwise: push {mem_rdata_i, pc_tag} and outstanding −= 1. pc_tag is an internal in-order PC counter that advances by 4 per accepted response.
- Output:
  - instr_valid_o = (fifo_count != 0); head is registered.
  - Latency is 1 cycle from rvalid to instr_valid_o; there is no combinational bypass.
- Pop: instr_valid_o && instr_ready_i && !redirect_i.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
- Redirect (redirect_i high, single-cycle effect):
  - FIFO cleared; fetch_pc and pc_tag = {redirect_pc_i[RegBits-1:2], 2'b00}.
  - discard_next = discard + outstanding + (grant this cycle) − (rvalid this cycle).
  - outstanding_next = 0.
  - mem_req_o is 0 in the redirect cycle. A grant cannot occur because mem_req_o is low, so (grant this cycle) is 0.
  - instr_valid_o is 0 from the next cycle until new-stream data arrives.
  - Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Response with no outstanding and no discard is a protocol error. It is ignored; the counters must not underflow.
- Reset asserted mid-operation clears all state immediately. In-flight responses after reset release are ignored via the underflow guard.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined:
  - Adds output port stall_cnt_o [31:0], reset to 0.
  - Increments each cycle instr_ready_i && !instr_valid_o && !redirect_i, saturating at 32'hFFFF_FFFF.
  - Also adds output redirect_cnt_o [15:0], which counts redirects and saturates.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory always grants, 1-cycle rvalid latency, ready=1 → addresses 0,4,8,… and instr_pc_o 0,4,8,…, first instr_valid_o 2 cycles after the first grant.
- ready=0, Depth=4 → exactly 4 grants issued, then mem_req_o=0 and FIFO full; ready=1 for one cycle → exactly one new grant follows.
- Two outstanding requests (PC 8, 12), redirect_pc_i=32'h100 → both late responses dropped; next head pc=32'h100 with the rdata returned for addr 32'h100.
- redirect_pc_i=32'h203 → mem_addr_o=32'h200, instr_pc_o=32'h200.
- fetch_pc=32'hFFFF_FFFC granted → next mem_addr_o=32'h0.
- PREFETCH_STATS_EN, ready=1 with memory never granting for 10 cycles → stall_cnt_o=10. Rvalid pulse with no outstanding request → no push, counters unchanged.
